// File: rtl/irq_pending_ctrl.sv
// Sticky rising-edge interrupt pending register with mask, presenting the
// highest-index eligible line as a stable valid/id pair retired by a 1-cycle ack.
module irq_pending_ctrl #(
  parameter int N   = 8,
  parameter int IDW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  input  logic           irq_ack,
  output logic           irq_valid,
  output logic [IDW-1:0] irq_id,
  output logic [N-1:0]   pending
);

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    GAP
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   req_q;
  logic [N-1:0]   pend_q, pend_d;
  logic           valid_q, valid_d;
  logic [IDW-1:0] id_q, id_d;

  logic [N-1:0]   rise;
  logic [N-1:0]   elig;
  logic [IDW-1:0] enc;
  logic           clr_en;

  assign rise = req & ~req_q;
  assign elig = pend_q & ~mask;

  // Scan upward so the last hit, i.e. the highest index, wins.
  always_comb begin
    enc = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (elig[i]) enc = IDW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    id_d    = id_q;
    clr_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          id_d    = enc;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (irq_ack) begin
          clr_en  = 1'b1;
          valid_d = 1'b0;
          id_d    = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        id_d    = '0;
      end
    endcase
  end

  // Clear is applied before the set so a same-cycle rise keeps the bit pending.
  always_comb begin
    pend_d = pend_q;
    if (clr_en) pend_d[id_q] = 1'b0;
    pend_d = pend_d | rise;
  end

  always_ff @(posedge clk) begin
    req_q <= req;
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  assign irq_valid = valid_q;
  assign irq_id    = id_q;
  assign pending   = pend_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed self-checking bench for irq_pending_ctrl.
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] mask;
  logic       irq_ack;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  irq_pending_ctrl #(.N(8), .IDW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mask      (mask),
    .irq_ack   (irq_ack),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects exp_id presented now; acks it, checks the clear, then waits out GAP.
  task automatic serve(input logic [2:0] exp_id, input logic [7:0] exp_pend);
    check("serve_valid", 32'(irq_valid), 32'd1);
    check("serve_id", 32'(irq_id), 32'(exp_id));
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("ack_valid", 32'(irq_valid), 32'd0);
    check("ack_id", 32'(irq_id), 32'd0);
    check("ack_pend", 32'(pending), 32'(exp_pend));
    step();
    check("gap_valid", 32'(irq_valid), 32'd0);
    step();
  endtask

  initial begin
    rst = 1'b1; req = '0; mask = '0; irq_ack = 1'b0;
    step(); step();
    check("rst_valid", 32'(irq_valid), 32'd0);
    check("rst_id", 32'(irq_id), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);
    rst = 1'b0;
    step();

    // 1/2: CC pattern, served 7,6,3,2
    req = 8'hCC;
    step();
    check("t1_pend", 32'(pending), 32'hCC);
    check("t1_valid_early", 32'(irq_valid), 32'd0);
    step();
    serve(3'd7, 8'h4C);
    serve(3'd6, 8'h0C);
    serve(3'd3, 8'h04);
    serve(3'd2, 8'h00);
    check("t2_idle_valid", 32'(irq_valid), 32'd0);
    check("t2_idle_id", 32'(irq_id), 32'd0);

    // 3: masked high line, then unmasked
    req = 8'h00; step();
    mask = 8'h80; req = 8'h84;
    step();
    check("t3_pend", 32'(pending), 32'h84);
    step();
    check("t3_valid", 32'(irq_valid), 32'd1);
    check("t3_id", 32'(irq_id), 32'd2);
    mask = 8'h84;
    step();
    check("t3_mask_hold", 32'(irq_id), 32'd2);
    check("t3_mask_valid", 32'(irq_valid), 32'd1);
    mask = 8'h00;
    serve(3'd2, 8'h80);
    serve(3'd7, 8'h00);

    // 4: no pre-emption
    req = 8'h00; step();
    req = 8'h08; step(); step();
    check("t4_id3", 32'(irq_id), 32'd3);
    req = 8'h48;
    step();
    check("t4_pend", 32'(pending), 32'h48);
    check("t4_hold", 32'(irq_id), 32'd3);
    serve(3'd3, 8'h40);
    serve(3'd6, 8'h00);

    // 5: held high through reset release
    rst = 1'b1; req = 8'h04;
    step(); step();
    rst = 1'b0;
    step(); step();
    check("t5_pend", 32'(pending), 32'h00);
    check("t5_valid", 32'(irq_valid), 32'd0);
    req = 8'h00; step();
    req = 8'h04; step(); step();
    serve(3'd2, 8'h00);

    // 6: same-cycle rise and ack clear of bit 5
    req = 8'h00; step();
    req = 8'h20; step(); step();
    check("t6_id5", 32'(irq_id), 32'd5);
    req = 8'h00; step();
    irq_ack = 1'b1; req = 8'h20;
    step();
    irq_ack = 1'b0;
    check("t6_setwins", 32'(pending), 32'h20);
    check("t6_gap_valid", 32'(irq_valid), 32'd0);
    step(); step();
    check("t6_re_valid", 32'(irq_valid), 32'd1);
    check("t6_re_id", 32'(irq_id), 32'd5);
    rst = 1'b1;
    step();
    check("t6_rst_valid", 32'(irq_valid), 32'd0);
    check("t6_rst_id", 32'(irq_id), 32'd0);
    check("t6_rst_pend", 32'(pending), 32'd0);
    rst = 1'b0;
    step(); step();
    check("t6_post_valid", 32'(irq_valid), 32'd0);

    // ack during GAP is ignored (would otherwise clear pending[0])
    req = 8'h03; step(); step();
    check("gap_id1", 32'(irq_id), 32'd1);
    irq_ack = 1'b1; step();
    check("gap_pend", 32'(pending), 32'h01);
    step();
    irq_ack = 1'b0;
    check("gap_ack_ign", 32'(pending), 32'h01);
    step();
    serve(3'd0, 8'h00);
    irq_ack = 1'b1; step();
    irq_ack = 1'b0;
    check("idle_ack_valid", 32'(irq_valid), 32'd0);
    check("idle_ack_pend", 32'(pending), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
